// File: rtl/dice_pkg.sv
// Shared constants, state encoding and die helpers for the dice roller.
package dice_pkg;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;
  localparam int          MAX_REJECT   = 4;
  localparam int          DIE_W        = 3;
  localparam int          NUM_DICE     = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROLL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] ROLL = ST_ROLL;
  localparam logic [1:0] DONE = ST_DONE;

  // Map an out-of-range draw onto a legal face: (raw mod 6) + 1.
  function automatic logic [DIE_W-1:0] forced_die(input logic [DIE_W-1:0] raw);
    logic [DIE_W-1:0] val;
    case (raw)
      3'd0:    val = 3'd1;
      3'd7:    val = 3'd2;
      default: val = raw;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/dice_roller_lfsr16_step.sv
// One step of the 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1), purely combinational.
module lfsr16_step (
  input  logic [15:0] cur,
  output logic [15:0] nxt
);
  import dice_pkg::*;

  assign nxt = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);

endmodule

// File: rtl/dice_roller.sv
// Seeded roll engine: draws six dice from an LFSR with bounded rejection
// and presents them atomically together with a valid flag.
module dice_roller #(
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1,
  parameter int          MAX_REJECT   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        roll,
  input  logic        seed_load,
  input  logic [15:0] seed,
  output logic [2:0]  D1,
  output logic [2:0]  D2,
  output logic [2:0]  D3,
  output logic [2:0]  D4,
  output logic [2:0]  D5,
  output logic [2:0]  D6,
  output logic        valid,
  output logic        busy
);
  import dice_pkg::*;

  localparam logic [1:0] REJ_LAST = 2'(MAX_REJECT - 1);

  logic [1:0]       state_r;
  logic [2:0]       idx_r;
  logic [1:0]       rej_r;
  logic [15:0]      lfsr_r;
  logic [15:0]      lfsr_next_s;
  logic             valid_r;
  logic             busy_r;
  logic [DIE_W-1:0] shadow_r [NUM_DICE];
  logic [DIE_W-1:0] dice_r   [NUM_DICE];

  logic [2:0]       draw_s;
  logic             accept_s;
  logic             force_s;
  logic             take_s;
  logic [DIE_W-1:0] die_val_s;

  lfsr16_step u_step (
    .cur (lfsr_r),
    .nxt (lfsr_next_s)
  );

  assign draw_s    = lfsr_next_s[2:0];
  assign accept_s  = (draw_s != 3'd0) && (draw_s != 3'd7);
  assign force_s   = !accept_s && (rej_r == REJ_LAST);
  assign take_s    = accept_s || force_s;
  assign die_val_s = accept_s ? draw_s : forced_die(draw_s);

  // Roll FSM, LFSR, shadow dice and the published output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= 3'd0;
      rej_r   <= 2'd0;
      lfsr_r  <= SEED_DEFAULT;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      for (int i = 0; i < NUM_DICE; i++) begin
        shadow_r[i] <= 3'd0;
        dice_r[i]   <= 3'd0;
      end
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (seed_load) begin
            lfsr_r <= (seed == 16'h0000) ? SEED_DEFAULT : seed;
          end else if (roll) begin
            state_r <= ROLL;
            idx_r   <= 3'd0;
            rej_r   <= 2'd0;
            valid_r <= 1'b0;
            busy_r  <= 1'b1;
          end else begin
            state_r <= state_r;
          end
        end
        ROLL: begin
          lfsr_r <= lfsr_next_s;
          if (take_s) begin
            rej_r <= 2'd0;
            for (int i = 0; i < NUM_DICE; i++) begin
              if (idx_r == 3'(i)) begin
                shadow_r[i] <= die_val_s;
              end else begin
                shadow_r[i] <= shadow_r[i];
              end
            end
            // The last die bypasses the shadow so the whole roll publishes on one edge.
            if (idx_r == 3'(NUM_DICE - 1)) begin
              for (int i = 0; i < NUM_DICE - 1; i++) begin
                dice_r[i] <= shadow_r[i];
              end
              dice_r[NUM_DICE-1] <= die_val_s;
              valid_r <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= DONE;
            end else begin
              idx_r <= idx_r + 3'd1;
            end
          end else begin
            rej_r <= rej_r + 2'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign D1    = dice_r[0];
  assign D2    = dice_r[1];
  assign D3    = dice_r[2];
  assign D4    = dice_r[3];
  assign D5    = dice_r[4];
  assign D6    = dice_r[5];
  assign valid = valid_r;
  assign busy  = busy_r;

endmodule

// File: doc/dice_roller.md
# dice_roller

Upstream stimulus stage for the six-dice prize evaluator (`Main`). It replaces hand-driven dice values with a seeded pseudo-random roll engine. On each roll request it produces six die values in the range 1..6 and presents them atomically on `D1`..`D6`, ready for direct connection to the evaluator's dice inputs. A `valid` flag marks a fresh, complete roll.

## Interface
Parameters:
- `SEED_DEFAULT`, 16'hACE1: LFSR state after reset; also substituted whenever a zero seed is loaded.
- `MAX_REJECT`, 4: consecutive rejected draws per die before a forced accept.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `roll`  in  1  roll request, sampled every edge.
- `seed_load`  in  1  load `seed` into the LFSR.
- `seed`  in  16  seed value.
- `D1`..`D6`  out  3 each  die values; connect straight to the evaluator's `D1`..`D6`.
- `valid`  out  1  high while `D1`..`D6` hold a completed roll.
- `busy`  out  1  high while a roll is in progress.

## Operation
- **LFSR:** 16-bit Galois generator, polynomial x^16+x^14+x^13+x^11+1. Step rule: `lsb=s[0]`, `s=s>>1`, and if `lsb` is set, `s^=16'hB400`.
- **FSM states:** IDLE (after reset), ROLL, DONE.
- **IDLE or DONE:**
  - `seed_load=1`: LFSR ← `seed`, or `SEED_DEFAULT` if `seed` is 0. Any `roll` in the same cycle is ignored. `valid` and the dice are unchanged.
  - Else `roll=1`: go to ROLL. Clear die index, reject counter and `valid`. The LFSR does not step on this edge.
- **ROLL**, on every edge:
  - Step the LFSR. Take `raw` = bits [2:0] of the new state.
  - If `raw` is in 1..6: accept it into shadow die[idx], increment idx, clear the reject counter.
  - Else, if the reject counter equals `MAX_REJECT-1`: forced accept of `(raw mod 6)+1` (0→1, 7→2) into die[idx], increment idx, clear the counter.
  - Else: increment the reject counter; idx is unchanged.
  - On the 6th accept: copy all shadow dice to `D1`..`D6` on the same edge, set `valid=1`, go to DONE.
- `roll` and `seed_load` are ignored in ROLL. There is no queuing, so a request during a roll is lost.
- `D1`..`D6` change only at roll completion and never show a partial roll.
- `busy` = (state == ROLL).

## Timing
- **Reset values:** `D1`..`D6`=0, `valid`=0, `busy`=0, state IDLE, LFSR=`SEED_DEFAULT`, idx=0, reject counter=0. Reset applies immediately and asynchronously, including mid-ROLL, and the partial roll is discarded.
- **Roll latency:**
  - `roll` is accepted at edge k; `busy` is high from after edge k.
  - Dice and `valid` are updated at edge k+N, where N = accepted draws + rejected draws.
  - N ranges from 6 (minimum) to 24 (maximum, with `MAX_REJECT`=4).
  - `busy` falls at edge k+N.
- **`valid` pulse:** `valid` falls at the edge that accepts the next `roll` (k+0 of that roll) and stays low until that roll completes.
- **Back-to-back rolls:** `roll` held high in DONE starts a new roll on the first DONE edge. The DONE state therefore lasts a minimum of one cycle.
- **Idle LFSR:** the LFSR steps only in ROLL. Identical seeds give identical roll sequences.

## Structure
- **Package `dice_pkg`:**
  - `LFSR_TAPS`=16'hB400
  - `SEED_DEFAULT`=16'hACE1
  - `MAX_REJECT`
  - state enum {IDLE, ROLL, DONE}
  - die width constant 3
- **Sub-module `lfsr16_step`:** purely combinational next-state function, reused by the bench's reference model.
- **Main block contents:** FSM, 3-bit idx, 2-bit reject counter, and the 6×3 shadow and output registers.

## Test plan
- **Reset:** assert `rst_n`=0 mid-simulation → all dice 0, `valid`=0, `busy`=0. Release, pulse `roll` without seeding → results identical to the default-seed case below.
- **Default seed:** after reset, pulse `roll` at edge k → `busy` for 9 cycles. At edge k+9, `D1..D6` = 4,6,3,1,4,2 and `valid`=1. This sequence has 2 rejects on die 1 and 1 reject on die 3.
- **Zero seed:** `seed_load` with `seed`=0, then `roll` → same 4,6,3,1,4,2 result with 9-cycle latency.
- **Requests while busy:** pulse `roll` and `seed_load` during ROLL → ignored. Exactly one completion occurs, and the dice match the undisturbed sequence.
- **Simultaneous requests:** `seed_load` and `roll` in the same cycle in DONE → seed is loaded, no roll starts, `valid` stays 1 with the dice unchanged.
- **Forced accept:** seed chosen by the reference model to give 4 consecutive raw 0/7 values for a die → forced value 1 or 2 accepted. Across a 1000-roll sweep, every die is in 1..6 and every latency is in 6..24.
